regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port among three writeback requesters: ALU (0), MEM/load (1) and DBG/loader (2).
- Arbitrates one request per cycle and registers the winner onto the register-file write port.
- Provides a hazard query for stall logic.
- Provides a debug lock that drains in-flight writes and then grants only DBG.

---
 rtl/regfile_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port among three writeback
// requesters: ALU (0), MEM/load (1) and DBG/loader (2). One request is granted
// per cycle. The winner's address and data are registered onto the write port,
// so a transfer in cycle N shows up as rf_write in cycle N+1. A debug lock
// first drains any in-flight write and then grants only DBG.
//
// Build option:
//   REGARB_ROUND_ROBIN_EN  defined   : round-robin arbitration in RUN. The
//                                      search starts after the last granted
//                                      index.
//                          undefined : fixed priority MEM(1) > ALU(0) > DBG(2),
//                                      with no pointer state.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester write request (bit i = requester i)
//   req_ready  per-requester grant, combinational, at most one bit set
//   req_addr   destination register per requester (slice i = requester i)
//   req_data   write data per requester (slice i = requester i)
//   dbg_lock   request exclusive DBG access
//   locked     registered, high while in LOCKED
//   rf_write   register-file write strobe
//   rf_addr    register-file write index
//   rf_data    register-file write data
//   q_addr     hazard query index
//   q_hit      q_addr has a pending request or an in-flight write
//   wr_count   saturating count of committed writes

module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic                dbg_lock,
  output logic                locked,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  input  logic [ADDR_W-1:0]   q_addr,
  output logic                q_hit,
  output logic [CNT_W-1:0]    wr_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        run_grant;
  logic [2:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              wr_d;

  // Priority pick: grant the first valid requester in the order p0, p1, p2.
  function automatic logic [2:0] pick(input logic [2:0] v,
                                      input logic [1:0] p0,
                                      input logic [1:0] p1,
                                      input logic [1:0] p2);
    logic [2:0] g;
    g = '0;
    if (v[p0])      g[p0] = 1'b1;
    else if (v[p1]) g[p1] = 1'b1;
    else if (v[p2]) g[p2] = 1'b1;
    return g;
  endfunction

`ifdef REGARB_ROUND_ROBIN_EN
  // Index of the last requester granted in RUN. Reset value 2 makes
  // requester 0 first in the rotation.
  logic [1:0] rr_ptr_q;

  always_comb begin
    case (rr_ptr_q)
      2'd0:    run_grant = pick(req_valid, 2'd1, 2'd2, 2'd0);
      2'd1:    run_grant = pick(req_valid, 2'd2, 2'd0, 2'd1);
      default: run_grant = pick(req_valid, 2'd0, 2'd1, 2'd2);
    endcase
  end

  // Only RUN transfers advance the rotation, so DBG grants made while
  // LOCKED leave the pointer where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 2'd2;
    end else if (state_q == RUN && xfer) begin
      rr_ptr_q <= grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
    end
  end
`else
  always_comb begin
    run_grant = pick(req_valid, 2'd1, 2'd0, 2'd2);
  end
`endif

  always_comb begin
    case (state_q)
      RUN:     grant = run_grant;
      LOCKED:  grant = {req_valid[2], 2'b00};
      default: grant = 3'b000;
    endcase
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  // Grant is one-hot or zero, so an AND-OR mux selects the winner's payload.
  // NOTE: every variable driven in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        win_addr = win_addr | req_addr[i*ADDR_W +: ADDR_W];
        win_data = win_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to register 0 are accepted but never reach the register file.
  assign wr_d = xfer && (win_addr != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dbg_lock) state_d = DRAIN;
      end
      DRAIN: begin
        // DRAIN grants nothing, so the output stage is always empty after
        // this edge. The lock is therefore reached one cycle after entry.
        if (!dbg_lock)  state_d = RUN;
        else if (!wr_d) state_d = LOCKED;
      end
      LOCKED: begin
        if (!dbg_lock) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      locked   <= 1'b0;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      wr_count <= '0;
    end else begin
      state_q  <= state_d;
      locked   <= (state_d == LOCKED);
      rf_write <= wr_d;
      // Address and data hold their last committed values between writes.
      if (wr_d) begin
        rf_addr <= win_addr;
        rf_data <= win_data;
      end
      if (rf_write && (wr_count != {CNT_W{1'b1}})) begin
        wr_count <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // A hit on register 0 is never reported because writes to it are dropped.
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == q_addr)) q_hit = 1'b1;
    end
    if (rf_write && (rf_addr == q_addr)) q_hit = 1'b1;
    if (q_addr == '0) q_hit = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;   // small counter so saturation is reached

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [3*AW-1:0]  req_addr;
  logic [3*DW-1:0]  req_data;
  logic             dbg_lock;
  logic             locked;
  logic             rf_write;
  logic [AW-1:0]    rf_addr;
  logic [DW-1:0]    rf_data;
  logic [AW-1:0]    q_addr;
  logic             q_hit;
  logic [CW-1:0]    wr_count;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .dbg_lock(dbg_lock), .locked(locked),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .q_addr(q_addr), .q_hit(q_hit), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus registers
  logic [2:0]    v;
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];

  always_comb begin
    req_valid = v;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: mode 0 = running, 1 = draining, 2 = locked
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            m_mode;
  int            m_last;
  int            m_count;
  logic          m_wv;
  logic [AW-1:0] m_wa;
  int            m_grant;

  task automatic model_reset();
    m_mode  = 0;
    m_last  = 2;
    m_count = 0;
    m_wv    = 1'b0;
    m_wa    = '0;
    m_grant = -1;
    exp_q.delete();
  endtask

  // Evaluate one cycle at the negedge: check combinational and registered
  // outputs against the model, then advance the model across the next edge.
  task automatic model_cycle();
    int   order[3];
    logic hit;
    int   limit;
    wr_t  w;
`ifdef REGARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) order[k] = (m_last + 1 + k) % 3;
`else
    order[0] = 1; order[1] = 0; order[2] = 2;
`endif
    m_grant = -1;
    if (m_mode == 0) begin
      for (int k = 0; k < 3; k++)
        if (m_grant < 0 && v[order[k]]) m_grant = order[k];
    end else if (m_mode == 2) begin
      if (v[2]) m_grant = 2;
    end

    hit = 1'b0;
    for (int i = 0; i < 3; i++) if (v[i] && a[i] == q_addr) hit = 1'b1;
    if (m_wv && m_wa == q_addr) hit = 1'b1;
    if (q_addr == 0) hit = 1'b0;

    check("req_ready", req_ready, (m_grant >= 0) ? 3'(1 << m_grant) : 3'b000);
    check("q_hit", q_hit, hit);
    check("locked", locked, (m_mode == 2));
    check("wr_count", wr_count, m_count);

    limit = (1 << CW) - 1;
    if (m_wv && m_count < limit) m_count++;

    if (m_grant >= 0 && a[m_grant] != 0) begin
      w.due  = cyc + 1;
      w.addr = a[m_grant];
      w.data = d[m_grant];
      exp_q.push_back(w);
      m_wv = 1'b1;
      m_wa = a[m_grant];
    end else begin
      m_wv = 1'b0;
    end

    if (m_mode == 0 && m_grant >= 0) m_last = m_grant;

    case (m_mode)
      0:       m_mode = dbg_lock ? 1 : 0;
      1:       m_mode = dbg_lock ? 2 : 0;
      default: m_mode = dbg_lock ? 2 : 0;
    endcase
  endtask

  // Monitor: compares the write port against the scoreboard every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        wr_t e;
        e = exp_q.pop_front();
        check("rf_write", rf_write, 1'b1);
        check("rf_addr", rf_addr, e.addr);
        check("rf_data", rf_data, e.data);
      end else begin
        check("rf_write_idle", rf_write, 1'b0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (m_grant >= 0) v[m_grant] = 1'b0;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    rst      = 1'b1;
    v        = '0;
    dbg_lock = 1'b0;
    #1;
    check("rst_rf_write", rf_write, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_wr_count", wr_count, 0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    v        = '0;
    dbg_lock = 1'b0;
    q_addr   = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    rst = 1'b1;
    #1;
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_ready", req_ready, 3'b000);
    check("rst_q_hit", q_hit, 1'b0);
    v = 3'b001;
    #1;
    check("rst_ready_alu", req_ready, 3'b001);
    do_reset();

    // Single write
    v[0] = 1'b1; a[0] = 5; d[0] = 32'hDEADBEEF;
    step(); step(); step();
    check("single_wr_count", wr_count, 1);

    // Contention ALU/MEM: MEM first, then ALU
    v[0] = 1'b1; a[0] = 3; d[0] = 32'h0000_0A03;
    v[1] = 1'b1; a[1] = 4; d[1] = 32'h0000_0B04;
    step(); step(); step();

    // Register 0 write is accepted and discarded
    q_addr = 0;
    v[1] = 1'b1; a[1] = 0; d[1] = 32'h1234;
    step(); step(); step();
    check("x0_wr_count", wr_count, 3);

    // Three-way contention, each requester re-asserting after its transfer
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i]) begin
          v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = 32'h100 * (k + 1) + i;
        end
      end
      step();
    end
    v = '0;
    step();

    // Hazard query while ALU is blocked by the lock
    dbg_lock = 1'b1;
    step(); step(); step();
    v[0] = 1'b1; a[0] = 7; d[0] = 32'h7777; q_addr = 7;
    step(); step();
    dbg_lock = 1'b0;
    step(); step(); step(); step();

    // Lock with a transfer in the same cycle, DBG-only grants, release
    v[0] = 1'b1; a[0] = 9; d[0] = 32'h9999;
    dbg_lock = 1'b1;
    step(); step(); step();
    v[0] = 1'b1; a[0] = 10; d[0] = 32'hAAAA;
    v[2] = 1'b1; a[2] = 11; d[2] = 32'hBBBB;
    step(); step(); step();
    dbg_lock = 1'b0;
    step(); step(); step();

    // Reset in the middle of a drain drops the in-flight write
    v[0] = 1'b1; a[0] = 12; d[0] = 32'hCCCC;
    dbg_lock = 1'b1;
    step();
    do_reset();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
      if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
      q_addr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    v = '0;
    dbg_lock = 1'b0;
    step(); step(); step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
